// File: rtl/serial_word_deserializer_if.sv
// Serial-in / parallel-out bus between the upstream bit source and the deserializer.
// The master drives the serial side; the slave (deserializer) drives the word side.
interface serial_word_deserializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             SI;
  logic             EN;
  logic             SYNC;
  logic [WIDTH-1:0] PO;
  logic             VALID;
  logic             BUSY;

  modport master (
    output SI,
    output EN,
    output SYNC,
    input  PO,
    input  VALID,
    input  BUSY
  );

  modport slave (
    input  SI,
    input  EN,
    input  SYNC,
    output PO,
    output VALID,
    output BUSY
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Assembles an MSB-first serial stream into WIDTH-bit words, strobing VALID for one
// cycle on the edge that samples the last bit of each word.
module serial_word_deserializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 4
) (
  input logic                      C,
  input logic                      RE,
  serial_word_deserializer_if.slave bus
);

  localparam logic [CNTW-1:0] LastCnt = CNTW'(WIDTH - 1);

  // Before completion at most WIDTH-1 bits are held, so the register's top bit is
  // always zero and is not stored.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {shreg_q, bus.SI};

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    po_d    = po_q;
    valid_d = 1'b0;
    if (bus.SYNC) begin
      // Realign: the current bit (if enabled) becomes bit 0 of a fresh word.
      shreg_d = '0;
      cnt_d   = '0;
      if (bus.EN) begin
        shreg_d[0] = bus.SI;
        cnt_d      = CNTW'(1);
      end
    end else if (bus.EN) begin
      if (cnt_q == LastCnt) begin
        po_d    = shifted;
        valid_d = 1'b1;
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        shreg_d = shifted[WIDTH-2:0];
        cnt_d   = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge C or posedge RE) begin
    if (RE) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      po_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      po_q    <= po_d;
      valid_q <= valid_d;
    end
  end

  assign bus.PO    = po_q;
  assign bus.VALID = valid_q;
  assign bus.BUSY  = (cnt_q != '0);

endmodule
